// File: rtl/smsdac_pkg.sv
// -----------------------------------------------------------------------------
// smsdac_pkg
// Shared constants, readout FSM state encoding and the element-to-level decode
// used by the segmented mismatch-shaping DAC monitor (and by the encoder's
// bench model).
// -----------------------------------------------------------------------------
package smsdac_pkg;

    localparam int         N_SEG      = 4;
    localparam int         CODE_W     = 5;
    localparam logic [4:0] CODE_MAX   = 5'd30;
    localparam int         FRAME_W    = 40;
    localparam logic [2:0] FRAME_SYNC = 3'b101;

    // Readout shifter state (legacy-compatible constant encoding)
    typedef logic [0:0] shift_state_t;
    localparam shift_state_t ST_IDLE  = 1'b0;
    localparam shift_state_t ST_SHIFT = 1'b1;

    // Decode the 8 unit-element drive bits into a level 0..30:
    // 8*(e7+e6) + 4*(e5+e4) + 2*(e3+e2) + e1 + e0
    function automatic logic [CODE_W-1:0] dac_level(input logic [7:0] elem);
        logic [1:0] w8;
        logic [1:0] w4;
        logic [1:0] w2;
        logic [1:0] w1;
        w8 = {1'b0, elem[7]} + {1'b0, elem[6]};
        w4 = {1'b0, elem[5]} + {1'b0, elem[4]};
        w2 = {1'b0, elem[3]} + {1'b0, elem[2]};
        w1 = {1'b0, elem[1]} + {1'b0, elem[0]};
        return {w8, 3'b000} + {1'b0, w4, 2'b00} + {2'b00, w2, 1'b0} + {3'b000, w1};
    endfunction

endpackage

// File: rtl/smsdac_frame_shifter.sv
// -----------------------------------------------------------------------------
// smsdac_frame_shifter
// Loads a readout frame on snap (IDLE only) and shifts it out MSB first, one bit
// per cycle, for W cycles. Runs independently of the datapath enable.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   snap        : single-cycle capture request (ignored while shifting)
//   frame       : frame to capture, MSB goes out first
//   sdo         : serial data (registered)
//   sdo_valid   : high while a frame bit is on sdo (registered)
//   busy        : high while in SHIFT
// -----------------------------------------------------------------------------
module smsdac_frame_shifter
    import smsdac_pkg::*;
#(
    parameter int W = FRAME_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         snap,
    input  logic [W-1:0] frame,
    output logic         sdo,
    output logic         sdo_valid,
    output logic         busy
);

    localparam int               CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(W - 1);

    shift_state_t     state_r;
    logic [W-1:0]     shreg_r;
    logic [CNT_W-1:0] cnt_r;
    logic             sdo_r;
    logic             sdo_valid_r;

    // Readout FSM: the capture cycle already presents bit 0, so the shift
    // register holds the remaining bits and cnt_r is the index on sdo.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            shreg_r     <= {W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            sdo_r       <= 1'b0;
            sdo_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (snap) begin
                        state_r     <= ST_SHIFT;
                        sdo_r       <= frame[W-1];
                        sdo_valid_r <= 1'b1;
                        shreg_r     <= {frame[W-2:0], 1'b0};
                        cnt_r       <= {CNT_W{1'b0}};
                    end else begin
                        sdo_r       <= 1'b0;
                        sdo_valid_r <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_r == LAST) begin
                        state_r     <= ST_IDLE;
                        sdo_r       <= 1'b0;
                        sdo_valid_r <= 1'b0;
                        cnt_r       <= {CNT_W{1'b0}};
                    end else begin
                        sdo_r       <= shreg_r[W-1];
                        sdo_valid_r <= 1'b1;
                        shreg_r     <= {shreg_r[W-2:0], 1'b0};
                        cnt_r       <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    sdo_r       <= 1'b0;
                    sdo_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign sdo       = sdo_r;
    assign sdo_valid = sdo_valid_r;
    assign busy      = (state_r == ST_SHIFT);

endmodule

// File: rtl/smsdac_monitor.sv
// -----------------------------------------------------------------------------
// smsdac_monitor
// Receive-side checker for the segmented mismatch-shaping DAC encoder: decodes
// the element bits, compares the level against the delayed input code,
// integrates each segment's switching sequence against a shaping bound, and
// offers a serial snapshot of the state.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : datapath sample enable (shifter ignores it)
//   in_code    : encoder input code 0..30
//   elem       : element drive bits, pairs of weight 8/4/2/1 from MSB down
//   err_clr    : clear sticky flags (a same-cycle detection wins)
//   snap       : capture a 40-bit readout frame
//   dec_code   : registered decoded level
//   code_err   : sticky level mismatch flag
//   seg_err    : sticky per-segment bound violation flags
//   sdo, sdo_valid, busy : serial readout
// -----------------------------------------------------------------------------
module smsdac_monitor
    import smsdac_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int ACC_W   = 8,
    parameter int BOUND   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [CODE_W-1:0] in_code,
    input  logic [7:0]        elem,
    input  logic              err_clr,
    input  logic              snap,
    output logic [CODE_W-1:0] dec_code,
    output logic              code_err,
    output logic [N_SEG-1:0]  seg_err,
    output logic              sdo,
    output logic              sdo_valid,
    output logic              busy
);

    localparam int                      FW        = N_SEG * ACC_W + 1 + N_SEG + 3;
    localparam int                      FILL_W    = 3;
    localparam logic [FILL_W-1:0]       FILL_FULL = FILL_W'(LATENCY + 1);
    localparam logic signed [ACC_W-1:0] BOUND_POS = ACC_W'(BOUND);
    localparam logic signed [ACC_W-1:0] BOUND_NEG = -BOUND_POS;

    logic [CODE_W-1:0]       dec_code_r;
    logic [CODE_W-1:0]       dly_r [LATENCY+1];
    logic [FILL_W-1:0]       fill_r;
    logic                    code_err_r;
    logic [N_SEG-1:0]        seg_err_r;
    logic signed [ACC_W-1:0] acc_r     [N_SEG];
    logic signed [ACC_W-1:0] acc_nxt_s [N_SEG];
    logic signed [ACC_W-1:0] step_s    [N_SEG];
    logic [N_SEG-1:0]        seg_hit_s;
    logic                    cmp_en_s;
    logic                    code_hit_s;
    logic [FW-1:0]           frame_s;

    // Per-segment step s_k = e[2k+1] - e[2k], next accumulator value and bound check
    always_comb begin
        for (int k = 0; k < N_SEG; k++) begin
            step_s[k]    = {ACC_W{1'b0}};
            acc_nxt_s[k] = {ACC_W{1'b0}};
            seg_hit_s[k] = 1'b0;
        end
        for (int k = 0; k < N_SEG; k++) begin
            case ({elem[2*k+1], elem[2*k]})
                2'b10:   step_s[k] = ACC_W'(1);
                2'b01:   step_s[k] = {ACC_W{1'b1}};
                default: step_s[k] = {ACC_W{1'b0}};
            endcase
            acc_nxt_s[k] = acc_r[k] + step_s[k];
            if (en && ((acc_nxt_s[k] > BOUND_POS) || (acc_nxt_s[k] < BOUND_NEG))) begin
                seg_hit_s[k] = 1'b1;
            end else begin
                seg_hit_s[k] = 1'b0;
            end
        end
    end

    // Level compare, only once the delay line holds real codes.
    // An out-of-range code can never be produced by the decode.
    always_comb begin
        cmp_en_s   = (fill_r == FILL_FULL);
        code_hit_s = 1'b0;
        if (en && cmp_en_s) begin
            code_hit_s = (dec_code_r != dly_r[LATENCY]) || (dly_r[LATENCY] > CODE_MAX);
        end else begin
            code_hit_s = 1'b0;
        end
    end

    // Datapath: decode, input-code delay line, fill counter, accumulators
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_code_r <= {CODE_W{1'b0}};
            fill_r     <= {FILL_W{1'b0}};
            for (int i = 0; i <= LATENCY; i++) begin
                dly_r[i] <= {CODE_W{1'b0}};
            end
            for (int k = 0; k < N_SEG; k++) begin
                acc_r[k] <= {ACC_W{1'b0}};
            end
        end else if (en) begin
            dec_code_r <= dac_level(elem);
            dly_r[0]   <= in_code;
            for (int i = 1; i <= LATENCY; i++) begin
                dly_r[i] <= dly_r[i-1];
            end
            if (!cmp_en_s) begin
                fill_r <= fill_r + FILL_W'(1);
            end
            for (int k = 0; k < N_SEG; k++) begin
                acc_r[k] <= acc_nxt_s[k];
            end
        end
    end

    // Sticky flags: a detection in the clear cycle keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_err_r <= 1'b0;
            seg_err_r  <= {N_SEG{1'b0}};
        end else begin
            code_err_r <= code_hit_s | (code_err_r & ~err_clr);
            seg_err_r  <= seg_hit_s | (seg_err_r & ~{N_SEG{err_clr}});
        end
    end

    // Frame holds pre-update state of the capture cycle, sync trailer last
    assign frame_s = {acc_r[3], acc_r[2], acc_r[1], acc_r[0], code_err_r, seg_err_r, FRAME_SYNC};

    smsdac_frame_shifter #(
        .W (FW)
    ) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .snap      (snap),
        .frame     (frame_s),
        .sdo       (sdo),
        .sdo_valid (sdo_valid),
        .busy      (busy)
    );

    assign dec_code = dec_code_r;
    assign code_err = code_err_r;
    assign seg_err  = seg_err_r;

endmodule

// File: tb/tb_smsdac_monitor.sv
// -----------------------------------------------------------------------------
// tb_smsdac_monitor
// Directed bench for smsdac_monitor (LATENCY=1, ACC_W=8, BOUND=2) with
// hand-computed expected values. Inputs change 1 ns after the rising edge and
// outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_smsdac_monitor;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [4:0] in_code;
    logic [7:0] elem;
    logic       err_clr;
    logic       snap;
    logic [4:0] dec_code;
    logic       code_err;
    logic [3:0] seg_err;
    logic       sdo;
    logic       sdo_valid;
    logic       busy;

    int n_total;
    int n_pass;

    smsdac_monitor #(
        .LATENCY (1),
        .ACC_W   (8),
        .BOUND   (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_code   (in_code),
        .elem      (elem),
        .err_clr   (err_clr),
        .snap      (snap),
        .dec_code  (dec_code),
        .code_err  (code_err),
        .seg_err   (seg_err),
        .sdo       (sdo),
        .sdo_valid (sdo_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        en      = 1'b1;
        snap    = 1'b0;
        err_clr = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Pulse snap and collect the serial frame; optionally pulse snap again at bit 10
    task automatic readout(input logic snap_mid, output logic [39:0] frm, output int nv, output int nb);
        snap = 1'b1;
        tick();
        snap = 1'b0;
        frm  = 40'h0;
        nv   = 0;
        nb   = 0;
        for (int c = 0; c < 46; c++) begin
            if (sdo_valid) begin
                frm = {frm[38:0], sdo};
                nv++;
            end
            if (busy) nb++;
            snap = (snap_mid && c == 10) ? 1'b1 : 1'b0;
            tick();
        end
        snap = 1'b0;
    endtask

    logic [4:0]  codes [5];
    logic [7:0]  encs  [5];
    logic [39:0] frm;
    int          nv;
    int          nb;

    initial begin
        n_total = 0;
        n_pass  = 0;
        codes = '{5'd0, 5'd15, 5'd30, 5'd7, 5'd7};
        encs  = '{8'h00, 8'hAA, 8'hFF, 8'h15, 8'h15};

        // ---- reset and fill period ----
        rst_n = 1'b0; en = 1'b1; snap = 1'b0; err_clr = 1'b0;
        elem = 8'hFF; in_code = 5'd30;
        #3;
        check_eq("rst_dec_code", 64'(dec_code), 64'd0);
        tick(); tick();
        check_eq("rst_dec_code_clk", 64'(dec_code), 64'd0);
        check_eq("rst_flags", 64'({code_err, seg_err}), 64'd0);
        check_eq("rst_serial", 64'({sdo, sdo_valid, busy}), 64'd0);
        rst_n = 1'b1;
        tick();
        check_eq("fill_dec_code", 64'(dec_code), 64'd30);
        check_eq("fill_code_err0", 64'(code_err), 64'd0);
        tick();
        check_eq("fill_code_err1", 64'(code_err), 64'd0);
        tick();
        check_eq("fill_code_err2", 64'(code_err), 64'd0);

        // ---- matched stream, elem lags in_code by one cycle ----
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_code = codes[i];
            elem    = (i == 0) ? 8'h00 : encs[i-1];
            tick();
            check_eq($sformatf("stream_dec_%0d", i), 64'(dec_code), (i == 0) ? 64'd0 : 64'(codes[i-1]));
            check_eq($sformatf("stream_err_%0d", i), 64'(code_err), 64'd0);
        end

        // ---- mismatch, sticky, clear, set-wins, illegal code 31 ----
        do_reset();
        in_code = 5'd2; elem = 8'h03;
        tick(); tick(); tick();
        check_eq("mm_pre", 64'(code_err), 64'd0);
        elem = 8'h01;
        tick();
        check_eq("mm_dec1", 64'(dec_code), 64'd1);
        elem = 8'h03;
        tick();
        check_eq("mm_set", 64'(code_err), 64'd1);
        tick();
        check_eq("mm_sticky", 64'(code_err), 64'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("mm_clr", 64'(code_err), 64'd0);
        elem = 8'h01;
        tick();
        elem = 8'h03; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("mm_setwins", 64'(code_err), 64'd1);
        check_eq("seg_at_neg_bound", 64'(seg_err), 64'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("mm_clr2", 64'(code_err), 64'd0);
        in_code = 5'd31;
        tick(); tick();
        check_eq("mm_31_pre", 64'(code_err), 64'd0);
        tick();
        check_eq("mm_31", 64'(code_err), 64'd1);

        // ---- en=0 freezes the datapath ----
        do_reset();
        in_code = 5'd2; elem = 8'h03;
        tick(); tick(); tick();
        en = 1'b0; elem = 8'h00; in_code = 5'd9;
        tick(); tick(); tick();
        check_eq("hold_dec", 64'(dec_code), 64'd2);
        check_eq("hold_err", 64'(code_err), 64'd0);
        en = 1'b1; in_code = 5'd2; elem = 8'h03;
        tick();
        check_eq("resume_err", 64'(code_err), 64'd0);

        // ---- segment 3 bound ----
        do_reset();
        in_code = 5'd8; elem = 8'h80;
        tick();
        check_eq("seg_acc1", 64'(seg_err), 64'd0);
        tick();
        check_eq("seg_acc2", 64'(seg_err), 64'd0);
        tick();
        check_eq("seg_acc3", 64'(seg_err), 64'h8);
        en = 1'b0;
        readout(1'b0, frm, nv, nb);
        check_eq("seg_frame_acc3", 64'(frm), 64'h03_0000_0045);
        en = 1'b1; elem = 8'h40;
        tick(); tick(); tick();
        check_eq("seg_stays", 64'(seg_err), 64'h8);
        check_eq("seg_code_ok", 64'(code_err), 64'd0);
        en = 1'b0;
        readout(1'b0, frm, nv, nb);
        check_eq("seg_frame_acc0", 64'(frm), 64'h00_0000_0045);

        // ---- accumulator wrap ----
        do_reset();
        in_code = 5'd1; elem = 8'h02;
        for (int i = 0; i < 128; i++) tick();
        en = 1'b0;
        readout(1'b0, frm, nv, nb);
        check_eq("wrap_frame", 64'(frm), 64'h00_0000_800D);

        // ---- readout framing with ignored second snap ----
        do_reset();
        in_code = 5'd1; elem = 8'h02;
        tick(); tick(); tick();
        en = 1'b0;
        readout(1'b1, frm, nv, nb);
        check_eq("ro_frame", 64'(frm), 64'h00_0000_030D);
        check_eq("ro_bits24_31", 64'(frm[15:8]), 64'h03);
        check_eq("ro_flags", 64'(frm[7:3]), 64'b0_0001);
        check_eq("ro_sync", 64'(frm[2:0]), 64'b101);
        check_eq("ro_nvalid", 64'(nv), 64'd40);
        check_eq("ro_nbusy", 64'(nb), 64'd40);
        check_eq("ro_after", 64'({sdo, sdo_valid, busy}), 64'd0);

        // ---- reset mid-frame aborts ----
        snap = 1'b1;
        tick();
        snap = 1'b0;
        tick(); tick();
        check_eq("abort_busy_pre", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_serial", 64'({sdo, sdo_valid, busy}), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("abort_idle", 64'({sdo_valid, busy}), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
